// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus between the execution units and the register file
// write arbiter.
//
// Handshake: a requester raises req_valid[i] and holds req_addr/req_data for
// slot i stable until it sees req_ready[i]. A write transfers in any cycle
// where req_valid[i] & req_ready[i] is true at the rising edge. req_ready is
// one-hot or zero, and the arbiter may assert it combinationally from valid.
//
// Signals:
//   req_valid  NUM_REQ     requester i has a pending writeback
//   req_ready  NUM_REQ     one-hot grant from the arbiter
//   req_addr   NUM_REQ*AW  destination register of requester i, slice [i*AW +: AW]
//   req_data   NUM_REQ*DW  write data of requester i, slice [i*DW +: DW]
// Modports:
//   master  writeback sources (drive valid/addr/data, observe ready)
//   slave   the arbiter (observe valid/addr/data, drive ready)
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 4,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register file write port between
// NUM_REQ writeback sources (0=ALU, 1=LSU, 2=MUL), with a per-register busy
// scoreboard (set when a destination is reserved at issue, cleared when the
// write to it is granted).
//
// Ports:
//   clk         clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   bus         writeback request bus (slave side), see the interface file
//   rsv_valid   reserve rsv_addr in the scoreboard at the next edge
//   rsv_addr    register to reserve
//   stall       freeze the write port: no grants this cycle
//   rf_we       registered register file write enable
//   rf_waddr    registered write address
//   rf_wdata    registered write data
//   grant_id    index of the requester behind the current rf_we pulse
//   busy        scoreboard, busy[r]=1 while a write to r is outstanding
//   dbg_rr_ptr  current round-robin pointer (highest-priority requester)
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = 16,
    parameter int AW       = 4,
    parameter int DW       = 32,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    regfile_write_arbiter_if.slave bus,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                stall,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic [GW-1:0]       grant_id,
    output logic [NUM_REGS-1:0] busy,
    output logic [GW-1:0]       dbg_rr_ptr
);

    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       grant_w;
    logic                grant_any;
    logic [GW-1:0]       rr_ptr_next;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_data;
    logic [NUM_REGS-1:0] busy_next;
    int                  idx;

    assign dbg_rr_ptr = rr_ptr;

    // Scan from rr_ptr upward with wrap-around; the first valid requester
    // wins. The pointer only ever holds 0..NUM_REQ-1, so a single
    // subtraction is enough for the modulo.
    always_comb begin
        grant_any = 1'b0;
        grant_w   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_w   = GW'(idx);
            end
        end
        if (stall) begin
            grant_any = 1'b0;
            grant_w   = '0;
        end
    end

    // Ready is asserted only for a valid winner, so grant_any is the transfer.
    assign bus.req_ready = grant_any ? (NUM_REQ'(1) << grant_w) : '0;

    assign sel_addr = bus.req_addr[int'(grant_w)*AW +: AW];
    assign sel_data = bus.req_data[int'(grant_w)*DW +: DW];

    assign rr_ptr_next = (grant_w == GW'(NUM_REQ - 1)) ? '0 : grant_w + GW'(1);

    // Clear for the granted write first, then apply the reservation, so a
    // new producer issued in the same cycle keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (grant_any) begin
            busy_next[sel_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            busy     <= '0;
        end else begin
            rf_we <= grant_any;
            busy  <= busy_next;
            if (grant_any) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                grant_id <= grant_w;
                rr_ptr   <= rr_ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    localparam int NUM_REQ  = 3;
    localparam int NUM_REGS = 16;
    localparam int AW       = 4;
    localparam int DW       = 32;
    localparam int GW       = 2;

    logic                clk;
    logic                reset;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic                stall;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic [GW-1:0]       grant_id;
    logic [NUM_REGS-1:0] busy;
    logic [GW-1:0]       dbg_rr_ptr;

    int total;
    int bad;

    logic [GW-1:0] exp_q[$];
    logic [GW-1:0] exp_g;
    logic [AW-1:0] slot_addr[NUM_REQ];

    regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr),
        .stall(stall),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .grant_id(grant_id),
        .busy(busy),
        .dbg_rr_ptr(dbg_rr_ptr)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
        slot_addr[i] = a;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        stall     = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) slot_addr[i] = '0;

        #2;
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_gid", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_ptr", dbg_rr_ptr, 0);
        tick();
        tick();
        reset = 1'b1;

        // single request from the ALU
        set_req(0, 4'd3, 32'hDEADBEEF);
        bus.req_valid = 3'b001;
        #1;
        check("t2_ready", bus.req_ready, 3'b001);
        tick();
        bus.req_valid = 3'b000;
        check("t2_we", rf_we, 1);
        check("t2_waddr", rf_waddr, 3);
        check("t2_wdata", rf_wdata, 32'hDEADBEEF);
        check("t2_gid", grant_id, 0);
        check("t2_ptr", dbg_rr_ptr, 1);
        tick();
        check("t2_we_drop", rf_we, 0);
        check("t2_waddr_hold", rf_waddr, 3);

        // all three valid from reset: strict rotation, back-to-back writes
        reset = 1'b0;
        #1;
        reset = 1'b1;
        check("t3_ptr_rst", dbg_rr_ptr, 0);
        set_req(0, 4'd1, 32'h1111_0000);
        set_req(1, 4'd2, 32'h2222_0000);
        set_req(2, 4'd4, 32'h4444_0000);
        for (int k = 0; k < 6; k++) exp_q.push_back(GW'(k % NUM_REQ));
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = exp_q.pop_front();
            #1;
            check("t3_ready", bus.req_ready, 3'b001 << exp_g);
            tick();
            check("t3_we", rf_we, 1);
            check("t3_gid", grant_id, exp_g);
            check("t3_waddr", rf_waddr, slot_addr[exp_g]);
        end
        bus.req_valid = 3'b000;
        check("t3_ptr_wrap", dbg_rr_ptr, 0);
        tick();
        check("t3_we_drop", rf_we, 0);

        // stall blocks the LSU for two cycles
        set_req(1, 4'd7, 32'h0000_0077);
        stall = 1'b1;
        bus.req_valid = 3'b010;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t4_stall_ready", bus.req_ready, 0);
            tick();
            check("t4_stall_we", rf_we, 0);
            check("t4_stall_ptr", dbg_rr_ptr, 0);
        end
        stall = 1'b0;
        #1;
        check("t4_ready", bus.req_ready, 3'b010);
        tick();
        bus.req_valid = 3'b000;
        check("t4_we", rf_we, 1);
        check("t4_gid", grant_id, 1);
        check("t4_wdata", rf_wdata, 32'h0000_0077);
        check("t4_ptr", dbg_rr_ptr, 2);

        // scoreboard
        rsv_valid = 1'b1;
        rsv_addr  = 4'd5;
        tick();
        rsv_valid = 1'b0;
        check("t5_rsv", busy, 16'h0020);
        set_req(0, 4'd5, 32'h5555_5555);
        bus.req_valid = 3'b001;
        tick();
        check("t5_wr_we", rf_we, 1);
        check("t5_wr_addr", rf_waddr, 5);
        check("t5_wr_clear", busy, 16'h0000);
        rsv_valid = 1'b1;
        rsv_addr  = 4'd5;
        tick();
        check("t5_same_we", rf_we, 1);
        check("t5_set_wins", busy, 16'h0020);
        rsv_addr = 4'd3;
        tick();
        check("t5_diff", busy, 16'h0008);
        bus.req_valid = 3'b000;
        rsv_addr = 4'd3;
        stall = 1'b1;
        tick();
        check("t5_rsv_again_stalled", busy, 16'h0008);
        stall = 1'b0;
        rsv_addr = 4'd5;
        tick();
        rsv_valid = 1'b0;
        check("t5_busy28", busy, 16'h0028);
        set_req(0, 4'd9, 32'h9999_9999);
        bus.req_valid = 3'b001;
        tick();
        bus.req_valid = 3'b000;
        check("t5_nonbusy_we", rf_we, 1);
        check("t5_nonbusy_busy", busy, 16'h0028);

        // asynchronous reset mid-cycle while a write is on the port
        #2;
        reset = 1'b0;
        #1;
        check("t1_we", rf_we, 0);
        check("t1_busy", busy, 0);
        check("t1_waddr", rf_waddr, 0);
        reset = 1'b1;
        check("t1_ptr", dbg_rr_ptr, 0);
        tick();

        // only the MUL valid at rr_ptr=0, then ALU+LSU
        set_req(2, 4'd12, 32'hCCCC_CCCC);
        bus.req_valid = 3'b100;
        #1;
        check("t6_ready2", bus.req_ready, 3'b100);
        tick();
        check("t6_gid2", grant_id, 2);
        check("t6_ptr0", dbg_rr_ptr, 0);
        set_req(0, 4'd1, 32'hA0A0_A0A0);
        set_req(1, 4'd2, 32'hB0B0_B0B0);
        bus.req_valid = 3'b011;
        #1;
        check("t6_ready0", bus.req_ready, 3'b001);
        tick();
        check("t6_gid0", grant_id, 0);
        check("t6_wdata0", rf_wdata, 32'hA0A0_A0A0);
        bus.req_valid = 3'b010;
        #1;
        check("t6_ready1", bus.req_ready, 3'b010);
        tick();
        bus.req_valid = 3'b000;
        check("t6_gid1", grant_id, 1);
        check("t6_we1", rf_we, 1);
        tick();
        check("t6_we_drop", rf_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
